exec_divmod_seq: RTL and testbench
==================================

Name: exec_divmod_seq

Overview:
- Multi-cycle sequencer for the execute stage's DIV/MOD operations.
- Accepts a divide/modulo request from the decode/execute control signals and stalls the pipeline while it iterates.
- Runs a radix-2 restoring division over WIDTH cycles, then returns a signed quotient or remainder to the execute-unit result mux with a one-cycle done pulse.
- Single-cycle ALU ops bypass this block entirely.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
SIGNED, 1, 1 = two's-complement signed divide (truncate toward zero); 0 = unsigned.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
start  input  1  request valid; sampled only in IDLE.
isDiv  input  1  request is DIV (quotient result).
isMod  input  1  request is MOD (remainder result); isDiv has priority if both are set.
op1  input  WIDTH  dividend.
op2  input  WIDTH  register divisor.
immx  input  WIDTH  immediate divisor.
isImmediate  input  1  1 selects immx as divisor, else op2.
flush  input  1  synchronous abort from branch/flush logic.
stall  output  1  holds the pipeline front end.
done  output  1  one-cycle pulse; result valid.
result  output  WIDTH  quotient or remainder.
divZero  output  1  divisor was zero; valid with done.

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, result=0, done=0, divZero=0, all internal registers cleared. Reset mid-operation discards the operation; no done follows.
- Accept: start=1 & (isDiv|isMod) in IDLE. start without isDiv/isMod is ignored. start in any other state is ignored; the requester must hold it until stall drops.
- stall = (accept condition in IDLE, combinational) | CALC | FIX. stall is 0 in DONE and IDLE.
- States: IDLE, CALC, FIX, DONE.
- Edge E0 (accept): latch op-select (isDiv wins), divisor = isImmediate ? immx : op2.
  - If SIGNED, latch the magnitudes of both operands, plus sign_q = sign(op1) XOR sign(divisor) and sign_r = sign(op1).
  - Divisor==0: go directly to DONE with result = isDiv ? all-ones : op1, and divZero=1.
  - Otherwise: remainder=0, counter=WIDTH-1, go to CALC.
- CALC, each edge: shift {rem,quo} left by 1 and trial-subtract the divisor magnitude. If no borrow, keep the difference and set quo LSB=1. Decrement the counter. After WIDTH edges (counter==0 at the edge), go to FIX.
- FIX, one edge: apply signs (negate quo if sign_q, negate rem if sign_r). Load result with the selected value, divZero=0, go to DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE. result and divZero hold until the next DONE load.
- Latency: done is high in the cycle after E(WIDTH+1), i.e. the cycle after E33 for WIDTH=32. For a zero divisor, done is high in the cycle after E0.
- Overflow: MIN_INT / -1 gives quotient 0x80000000 with remainder 0 (wraps, no flag). Magnitudes use WIDTH-bit unsigned, so |MIN_INT| = 0x80000000 is handled exactly.
- flush=1 at an edge in CALC/FIX/DONE: go to IDLE, no done pulse, result unchanged. flush has priority over accept in IDLE, so the request is dropped.
- Simultaneous flush and zero-divisor accept: flush wins.

Decomposition:
- Shared package: state encoding (IDLE/CALC/FIX/DONE), WIDTH default, the DIV-by-zero quotient constant (all-ones).
- Optional sub-module divmod_step: one combinational restoring step (shift, trial subtract, select). The FSM, counter and sign logic stay in exec_divmod_seq.

Test Plan:
- op1=100, op2=7, isDiv, start for 1 cycle: stall high from the start cycle through FIX; done in the cycle after E33; result=14, divZero=0.
- op1=-100 (0xFFFFFF9C), op2=7, isMod: result=0xFFFFFFFE (-2). Repeat with isDiv: result=0xFFFFFFF2 (-14).
- op1=10, op2=0, immx=3, isImmediate=1, isDiv: result=3. Then op2=0, isImmediate=0, isDiv: done the cycle after E0, result=0xFFFFFFFF, divZero=1. Same with isMod: result=10.
- op1=0x80000000, op2=0xFFFFFFFF, isDiv: result=0x80000000. isMod: result=0.
- Mid-operation: start 100/7, flush at CALC cycle 10: no done, state IDLE, stall 0, result keeps its old value. A new start next cycle completes normally. A second start issued during CALC is ignored (exactly one done).
- Assert reset=0 asynchronously at CALC cycle 5: stall, done, result, divZero go to 0 immediately. After release, a new 9/3 request gives result=3.

Source files
------------

// File: rtl/exec_divmod_seq_pkg.sv
// Shared definitions for the multi-cycle DIV/MOD sequencer: state encoding,
// default datapath width and the quotient returned on a zero divisor.
package exec_divmod_seq_pkg;

    // Default operand/result width; one restoring iteration per bit.
    localparam int DEFAULT_WIDTH = 32;

    // A DIV by zero returns a quotient with every bit set. The bit is
    // replicated to the instance width by the sequencer.
    localparam logic DIV_ZERO_QUO_BIT = 1'b1;

    // Sequencer states.
    //   IDLE : waiting for a DIV/MOD request
    //   CALC : WIDTH restoring iterations on the magnitudes
    //   FIX  : sign correction and result load
    //   DONE : one-cycle result-valid pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } divState_t;

endpackage

// File: rtl/exec_divmod_seq_if.sv
// Request/response bundle between the execute-stage control and the DIV/MOD
// sequencer.
//
// Handshake: start is the request valid. A request is taken at the rising
// edge where the sequencer is IDLE, start=1, (isDiv|isMod)=1 and flush=0.
// stall is the busy indication: it is high combinationally in the accepting
// cycle and stays high through CALC and FIX, so the requester must keep
// start and the operands stable until stall is seen low. done is a
// one-cycle pulse; result and divZero are valid with it and then hold until
// the next completed operation.
interface exec_divmod_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             isDiv;
    logic             isMod;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] immx;
    logic             isImmediate;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             divZero;

    // Requester side (execute control / operand mux).
    modport master (
        output start, isDiv, isMod, op1, op2, immx, isImmediate, flush,
        input  stall, done, result, divZero
    );

    // Sequencer side.
    modport slave (
        input  start, isDiv, isMod, op1, op2, immx, isImmediate, flush,
        output stall, done, result, divZero
    );
endinterface

// File: rtl/exec_divmod_seq_step.sv
// One radix-2 restoring division step on unsigned magnitudes: shift the
// {remainder, quotient} pair left by one, trial-subtract the divisor from
// the widened partial remainder and keep the difference when it does not
// borrow. The new quotient bit is the inverted borrow.
module exec_divmod_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    // Shift, trial subtract and select. The partial remainder is kept
    // below the divisor, so after a successful subtract the difference fits
    // in WIDTH bits and the low WIDTH bits of the subtraction are exact.
    always_comb begin
        shifted = {remIn, quoIn[WIDTH-1]};
        borrow  = (shifted < {1'b0, divisor});
        diff    = shifted[WIDTH-1:0] - divisor;
        remOut  = borrow ? shifted[WIDTH-1:0] : diff;
        quoOut  = {quoIn[WIDTH-2:0], ~borrow};
    end
endmodule

// File: rtl/exec_divmod_seq.sv
// Multi-cycle DIV/MOD sequencer for the execute stage. A request latches the
// operand magnitudes and signs, runs WIDTH restoring iterations, applies the
// signs in a fix-up cycle and presents the quotient or remainder with a
// one-cycle done pulse. A zero divisor skips the iterations entirely.
module exec_divmod_seq
    import exec_divmod_seq_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    exec_divmod_seq_if.slave     bus,
    output divState_t            dbgState
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    divState_t        state;
    logic [CW-1:0]    counter;
    logic             isDivQ;
    logic             signQ;
    logic             signR;
    logic [WIDTH-1:0] divMag;
    logic [WIDTH-1:0] remQ;
    logic [WIDTH-1:0] quoQ;
    logic [WIDTH-1:0] resultQ;
    logic             doneQ;
    logic             divZeroQ;

    logic             accept;
    logic [WIDTH-1:0] divisorSel;
    logic             op1Neg;
    logic             divNeg;
    logic [WIDTH-1:0] op1Mag;
    logic [WIDTH-1:0] divSelMag;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] quoSigned;
    logic [WIDTH-1:0] remSigned;

    // Request decode: flush outranks a new request, so a flushed request
    // neither starts nor raises stall.
    always_comb begin
        accept     = (state == IDLE) && bus.start && (bus.isDiv || bus.isMod) && !bus.flush;
        divisorSel = bus.isImmediate ? bus.immx : bus.op2;
    end

    // Operand magnitudes. WIDTH-bit unsigned magnitudes keep |MIN_INT| exact.
    always_comb begin
        op1Neg    = SIGNED && bus.op1[WIDTH-1];
        divNeg    = SIGNED && divisorSel[WIDTH-1];
        op1Mag    = op1Neg ? -bus.op1 : bus.op1;
        divSelMag = divNeg ? -divisorSel : divisorSel;
    end

    // Sign fix-up of the unsigned quotient and remainder. The quotient takes
    // the XOR of the operand signs, the remainder follows the dividend, which
    // gives truncation toward zero. MIN_INT / -1 wraps back to MIN_INT.
    always_comb begin
        quoSigned = signQ ? -quoQ : quoQ;
        remSigned = signR ? -remQ : remQ;
    end

    exec_divmod_seq_step #(
        .WIDTH (WIDTH)
    ) uStep (
        .remIn   (remQ),
        .quoIn   (quoQ),
        .divisor (divMag),
        .remOut  (remNext),
        .quoOut  (quoNext)
    );

    // Sequencer FSM with registered datapath and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            counter  <= '0;
            isDivQ   <= 1'b0;
            signQ    <= 1'b0;
            signR    <= 1'b0;
            divMag   <= '0;
            remQ     <= '0;
            quoQ     <= '0;
            resultQ  <= '0;
            doneQ    <= 1'b0;
            divZeroQ <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (bus.flush) begin
                // Abort: drop any operation in flight, keep the last result.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            isDivQ <= bus.isDiv;
                            signQ  <= op1Neg ^ divNeg;
                            signR  <= op1Neg;
                            divMag <= divSelMag;
                            if (divisorSel == '0) begin
                                resultQ  <= bus.isDiv ? {WIDTH{DIV_ZERO_QUO_BIT}} : bus.op1;
                                divZeroQ <= 1'b1;
                                doneQ    <= 1'b1;
                                state    <= DONE;
                            end else begin
                                remQ    <= '0;
                                quoQ    <= op1Mag;
                                counter <= LAST_CNT;
                                state   <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        remQ <= remNext;
                        quoQ <= quoNext;
                        if (counter == '0) begin
                            state <= FIX;
                        end else begin
                            counter <= counter - CNT_ONE;
                        end
                    end
                    FIX: begin
                        resultQ  <= isDivQ ? quoSigned : remSigned;
                        divZeroQ <= 1'b0;
                        doneQ    <= 1'b1;
                        state    <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Outputs: stall covers the accepting cycle plus the busy states.
    assign bus.stall   = accept || (state == CALC) || (state == FIX);
    assign bus.done    = doneQ;
    assign bus.result  = resultQ;
    assign bus.divZero = divZeroQ;
    assign dbgState    = state;

endmodule

// File: tb/tb_exec_divmod_seq.sv
// Bench for the DIV/MOD sequencer: directed steps from the test plan, a
// flush/reset/ignored-start section and a randomized block checked against a
// 64-bit arithmetic reference.
module tb_exec_divmod_seq;
    import exec_divmod_seq_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_INT = 32'h8000_0000;
    localparam logic [W-1:0] ALL_ONE = 32'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exec_divmod_seq_if #(.WIDTH(W)) bus ();
    divState_t dbgState;

    exec_divmod_seq #(
        .WIDTH  (W),
        .SIGNED (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .dbgState (dbgState)
    );

    // ---------------- scoreboard ----------------
    int checkCount = 0;
    int passCount  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] lastResult;
    logic         lastDz;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic checkState(input string tag, input divState_t obs, input divState_t exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %s expected %s", tag, obs.name(), exp.name());
    endtask

    // Reference: signed truncating division done in 64-bit arithmetic so
    // MIN_INT / -1 cannot overflow; the low word is the wrapped result.
    function automatic logic [W-1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] d,
                                              input logic wantQuo);
        longint sa, sd, q, r;
        if (d == '0) return wantQuo ? ALL_ONE : a;
        sa = longint'($signed(a));
        sd = longint'($signed(d));
        q  = sa / sd;
        r  = sa % sd;
        return wantQuo ? q[W-1:0] : r[W-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idleInputs();
        bus.start       = 1'b0;
        bus.isDiv       = 1'b0;
        bus.isMod       = 1'b0;
        bus.op1         = '0;
        bus.op2         = '0;
        bus.immx        = '0;
        bus.isImmediate = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                         input logic useImm, input logic selDiv, input logic selMod);
        bus.op1         = a;
        bus.op2         = b;
        bus.immx        = imm;
        bus.isImmediate = useImm;
        bus.isDiv       = selDiv;
        bus.isMod       = selMod;
        bus.start       = 1'b1;
    endtask

    // Issue one request, wait (bounded) for done and check latency, stall,
    // result, divZero and the single-cycle pulse.
    task automatic doOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] imm, input logic useImm, input logic selDiv,
                        input logic selMod, input logic [W-1:0] expRes, input logic expDz);
        int cycles;
        logic stallOk;
        logic [W-1:0] want;
        @(negedge clk);
        drive(a, b, imm, useImm, selDiv, selMod);
        #1 checkBit({tag, "/stall_accept"}, bus.stall, 1'b1);
        exp_q.push_back(expRes);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cycles  = 1;
        stallOk = 1'b1;
        while (bus.done !== 1'b1 && cycles < 200) begin
            if (bus.stall !== 1'b1) stallOk = 1'b0;
            @(negedge clk);
            cycles++;
        end
        check({tag, "/latency"}, W'(cycles), expDz ? W'(1) : W'(W + 2));
        checkBit({tag, "/stall_busy"}, stallOk, 1'b1);
        checkBit({tag, "/stall_done"}, bus.stall, 1'b0);
        want = exp_q.pop_front();
        check({tag, "/result"}, bus.result, want);
        checkBit({tag, "/divZero"}, bus.divZero, expDz);
        lastResult = want;
        lastDz     = expDz;
        @(negedge clk);
        checkBit({tag, "/done_pulse"}, bus.done, 1'b0);
        check({tag, "/result_hold"}, bus.result, lastResult);
        checkBit({tag, "/divZero_hold"}, bus.divZero, lastDz);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int cycles;
        int doneCount;
        logic [W-1:0] seen;
        idleInputs();
        reset = 1'b0;
        lastResult = '0;
        lastDz = 1'b0;
        #3;
        checkBit("reset/stall", bus.stall, 1'b0);
        checkBit("reset/done", bus.done, 1'b0);
        check("reset/result", bus.result, '0);
        checkBit("reset/divZero", bus.divZero, 1'b0);
        checkState("reset/state", dbgState, IDLE);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed values from the test plan.
        doOp("div_100_7",  32'd100, 32'd7, '0, 1'b0, 1'b1, 1'b0, 32'd14, 1'b0);
        doOp("mod_m100_7", 32'hFFFF_FF9C, 32'd7, '0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        doOp("div_m100_7", 32'hFFFF_FF9C, 32'd7, '0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF2, 1'b0);
        doOp("div_imm",    32'd10, 32'd0, 32'd3, 1'b1, 1'b1, 1'b0, 32'd3, 1'b0);
        doOp("div_zero",   32'd10, 32'd0, 32'd3, 1'b0, 1'b1, 1'b0, ALL_ONE, 1'b1);
        doOp("mod_zero",   32'd10, 32'd0, 32'd3, 1'b0, 1'b0, 1'b1, 32'd10, 1'b1);
        doOp("div_ovf",    MIN_INT, ALL_ONE, '0, 1'b0, 1'b1, 1'b0, MIN_INT, 1'b0);
        doOp("mod_ovf",    MIN_INT, ALL_ONE, '0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        doOp("div_prio",   32'd45, 32'd6, '0, 1'b0, 1'b1, 1'b1, 32'd7, 1'b0);
        doOp("mod_pos_neg", 32'd45, 32'hFFFF_FFFA, '0, 1'b0, 1'b0, 1'b1, 32'd3, 1'b0);

        // Start without an op select is ignored.
        @(negedge clk);
        drive(32'd9, 32'd3, '0, 1'b0, 1'b0, 1'b0);
        #1 checkBit("noop/stall", bus.stall, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        checkState("noop/state", dbgState, IDLE);

        // Flush together with a zero-divisor accept: flush wins.
        @(negedge clk);
        drive(32'd5, 32'd0, '0, 1'b0, 1'b1, 1'b0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checkBit("flush_idle/done", bus.done, 1'b0);
        checkState("flush_idle/state", dbgState, IDLE);
        check("flush_idle/result", bus.result, lastResult);
        checkBit("flush_idle/divZero", bus.divZero, lastDz);

        // Flush in CALC cycle 10: no done, result unchanged.
        @(negedge clk);
        drive(32'd100, 32'd7, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        checkState("flush_calc/state_before", dbgState, CALC);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checkState("flush_calc/state", dbgState, IDLE);
        checkBit("flush_calc/stall", bus.stall, 1'b0);
        checkBit("flush_calc/done", bus.done, 1'b0);
        check("flush_calc/result", bus.result, lastResult);
        doOp("after_flush", 32'd100, 32'd7, '0, 1'b0, 1'b1, 1'b0, 32'd14, 1'b0);

        // A second start during CALC is ignored: exactly one done, first result.
        @(negedge clk);
        drive(32'd20, 32'd3, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        doneCount = 0;
        seen = '0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) drive(32'd50, 32'd5, '0, 1'b0, 1'b1, 1'b0);
            if (c == 20) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                doneCount++;
                seen = bus.result;
            end
            @(negedge clk);
        end
        check("second_start/done_count", W'(doneCount), W'(1));
        check("second_start/result", seen, 32'd6);
        lastResult = 32'd6;

        // Async reset in CALC cycle 5, with divZero set beforehand.
        doOp("pre_reset_zero", 32'd7, 32'd0, '0, 1'b0, 1'b1, 1'b0, ALL_ONE, 1'b1);
        @(negedge clk);
        drive(32'd1000, 32'd7, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkBit("async_reset/stall", bus.stall, 1'b0);
        checkBit("async_reset/done", bus.done, 1'b0);
        check("async_reset/result", bus.result, '0);
        checkBit("async_reset/divZero", bus.divZero, 1'b0);
        checkState("async_reset/state", dbgState, IDLE);
        @(negedge clk);
        reset = 1'b1;
        cycles = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) cycles++;
            @(negedge clk);
        end
        check("async_reset/no_done", W'(cycles), W'(0));
        doOp("after_reset", 32'd9, 32'd3, '0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b, imm, d;
            logic useImm, selDiv, selMod;
            int kind;
            a = $urandom();
            if ($urandom_range(0, 7) == 0) a = MIN_INT;
            kind = $urandom_range(0, 9);
            case (kind)
                0:       d = '0;
                1:       d = ALL_ONE;
                2:       d = 32'd1;
                3:       d = MIN_INT;
                4, 5:    d = W'($urandom_range(1, 100));
                default: d = $urandom();
            endcase
            useImm = 1'($urandom_range(0, 1));
            if (useImm) begin
                imm = d;
                b   = $urandom();
            end else begin
                b   = d;
                imm = $urandom();
            end
            selDiv = 1'($urandom_range(0, 1));
            selMod = selDiv ? 1'($urandom_range(0, 1)) : 1'b1;
            doOp($sformatf("rand%0d", i), a, b, imm, useImm, selDiv, selMod,
                 refModel(a, d, selDiv), (d == '0));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
